// File: rtl/clk_div_pkg.sv
// Shared constants and ratio helpers for the programmable clock divider.
package clk_div_pkg;

    localparam int MIN_DIV = 2;

    function automatic logic [31:0] half(input logic [31:0] n);
        return n >> 1;
    endfunction

    function automatic logic is_odd(input logic [31:0] n);
        return n[0];
    endfunction

endpackage

// File: rtl/clk_div_neg_retime.sv
// Single falling-edge flop that delays the divider high phase by half a source clock.
module clk_div_neg_retime (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic hi_q;

    always_ff @(negedge clk or posedge reset) begin
        if (reset) hi_q <= 1'b0;
        else       hi_q <= d;
    end

    assign q = hi_q;

endmodule

// File: rtl/clk_div_prog.sv
// Run-time programmable 50%-duty integer divider; new ratios apply only at a period
// boundary (or immediately when idle) so clk_out never produces a runt pulse.
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] div_val,
    input  logic             div_load,
    output logic             div_ack,
    output logic             div_err,
    output logic             clk_out,
    output logic             tick
);

    localparam logic [WIDTH-1:0] DEF_N = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] MIN_N = WIDTH'(MIN_DIV);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic             running_q, running_d;
    logic             odd_q, odd_d;
    logic             pos_hi_q, pos_hi_d;
    logic             tick_q, tick_d;
    logic             div_ack_q, div_ack_d;
    logic             div_err_q, div_err_d;
    logic             boundary;
    logic             apply;
    logic [WIDTH-1:0] half_n;
    logic             neg_hi;

    always_comb begin
        boundary   = running_q && (cnt_q == n_q - WIDTH'(1));
        // Idle counts as a boundary for ratio updates: nothing is being shaped yet.
        apply      = pend_vld_q && (boundary || !running_q);
        n_d        = n_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        div_ack_d  = 1'b0;
        div_err_d  = 1'b0;

        if (apply) begin
            n_d        = pend_q;
            pend_vld_d = 1'b0;
            div_ack_d  = 1'b1;
        end

        // A load on the applying cycle re-arms pending after the old value took effect.
        if (div_load) begin
            if (div_val >= MIN_N) begin
                pend_d     = div_val;
                pend_vld_d = 1'b1;
            end else begin
                div_err_d = 1'b1;
            end
        end

        if (running_q) begin
            running_d = boundary ? en : 1'b1;
            cnt_d     = boundary ? '0 : cnt_q + WIDTH'(1);
        end else begin
            running_d = en;
            cnt_d     = '0;
        end

        odd_d    = (boundary || !running_q) ? is_odd(32'(n_d)) : odd_q;
        half_n   = WIDTH'(half(32'(n_d)));
        pos_hi_d = running_d && (cnt_d < half_n);
        tick_d   = running_d && (cnt_d == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q      <= '0;
            n_q        <= DEF_N;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            running_q  <= 1'b0;
            odd_q      <= is_odd(32'(DEFAULT_DIV));
            pos_hi_q   <= 1'b0;
            tick_q     <= 1'b0;
            div_ack_q  <= 1'b0;
            div_err_q  <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            n_q        <= n_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            running_q  <= running_d;
            odd_q      <= odd_d;
            pos_hi_q   <= pos_hi_d;
            tick_q     <= tick_d;
            div_ack_q  <= div_ack_d;
            div_err_q  <= div_err_d;
        end
    end

    clk_div_neg_retime u_neg_retime (
        .clk   (clk),
        .reset (reset),
        .d     (pos_hi_q),
        .q     (neg_hi)
    );

    // Odd ratios stretch the high phase by the half cycle held in neg_hi.
    assign clk_out = odd_q ? (pos_hi_q | neg_hi) : pos_hi_q;
    assign tick    = tick_q;
    assign div_ack = div_ack_q;
    assign div_err = div_err_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog: ratio table plus hand-written start/stop/load/reset sequences.
module tb_clk_div_prog;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [7:0] div_val;
    logic       div_load;
    logic       div_ack;
    logic       div_err;
    logic       clk_out;
    logic       tick;

    int total = 0;
    int bad   = 0;
    int ack_cnt = 0;
    int err_cnt = 0;
    int tick_cnt = 0;

    clk_div_prog #(.WIDTH(8), .DEFAULT_DIV(6)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .div_val  (div_val),
        .div_load (div_load),
        .div_ack  (div_ack),
        .div_err  (div_err),
        .clk_out  (clk_out),
        .tick     (tick)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (div_ack) ack_cnt++;
        if (div_err) err_cnt++;
        if (tick)    tick_cnt++;
    end

    typedef struct {
        int ratio;
        int exp_per;
        int exp_hi_halves;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int v);
        div_val  = 8'(v);
        div_load = 1'b1;
        step();
        div_load = 1'b0;
    endtask

    task automatic wait_tick(input string nm, input int budget);
        bit ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            step();
            if (tick) ok = 1;
        end
        check({nm, "_tick_seen"}, int'(ok), 1);
    endtask

    // Called at posedge+1 of a tick; samples every half clock until the next tick.
    task automatic measure(output int per, output int hi, output int first_lo);
        per = 0; hi = 0; first_lo = -1;
        for (int k = 0; k < 1200; k++) begin
            if (clk_out) hi++;
            else if (first_lo < 0) first_lo = k;
            #5;
            if (k % 2 == 1) begin
                per++;
                if (tick) break;
            end
        end
    endtask

    initial begin
        int per, hi, flo, a0, e0, t0, h;
        bit got;

        vecs[0] = '{5,   5,   5};
        vecs[1] = '{2,   2,   2};
        vecs[2] = '{3,   3,   3};
        vecs[3] = '{8,   8,   8};
        vecs[4] = '{255, 255, 255};
        vecs[5] = '{6,   6,   6};

        reset = 1'b1; en = 1'b0; div_val = '0; div_load = 1'b0;
        #1;
        check("rst_clk_out", int'(clk_out), 0);
        check("rst_tick",    int'(tick),    0);
        check("rst_ack",     int'(div_ack), 0);
        check("rst_err",     int'(div_err), 0);
        #21 reset = 1'b0;
        step();
        check("idle_clk_out", int'(clk_out), 0);

        // Start from idle with the default ratio: one clock to the first edge.
        en = 1'b1;
        step();
        check("start_tick",    int'(tick),    1);
        check("start_clk_out", int'(clk_out), 1);
        check("start_no_ack",  int'(div_ack), 0);
        measure(per, hi, flo);
        check("def_period",  per, 6);
        check("def_hi",      hi,  6);
        check("def_first_lo", flo, 6);

        for (int v = 0; v < 6; v++) begin
            load(vecs[v].ratio);
            got = 0;
            for (int i = 0; i < 300 && !got; i++) begin
                step();
                if (div_ack) got = 1;
            end
            check($sformatf("n%0d_ack", vecs[v].ratio), int'(got), 1);
            check($sformatf("n%0d_ack_on_tick", vecs[v].ratio), int'(tick), 1);
            measure(per, hi, flo);
            check($sformatf("n%0d_period", vecs[v].ratio), per, vecs[v].exp_per);
            check($sformatf("n%0d_hi_halves", vecs[v].ratio), hi, vecs[v].exp_hi_halves);
            check($sformatf("n%0d_first_lo", vecs[v].ratio), flo, vecs[v].exp_hi_halves);
        end

        // Illegal ratio is dropped with an error pulse.
        a0 = ack_cnt; e0 = err_cnt;
        load(1);
        check("err_pulse", int'(div_err), 1);
        step();
        check("err_one_cycle", int'(div_err), 0);
        wait_tick("err", 20);
        measure(per, hi, flo);
        check("err_period_kept", per, 6);
        check("err_count", err_cnt - e0, 1);
        check("err_no_ack", ack_cnt - a0, 0);

        // Two loads in one period: only the latest applies, with one ack.
        a0 = ack_cnt;
        div_val = 8'd7; div_load = 1'b1;
        step();
        div_val = 8'd9;
        step();
        div_load = 1'b0;
        wait_tick("dbl", 20);
        measure(per, hi, flo);
        check("dbl_period1", per, 9);
        measure(per, hi, flo);
        check("dbl_period2", per, 9);
        check("dbl_one_ack", ack_cnt - a0, 1);

        // Stop mid-period at N=8: the period completes, then clk_out holds low.
        load(8);
        wait_tick("stop", 20);
        hi = 0;
        for (int i = 0; i < 8; i++) begin
            hi += int'(clk_out); #5;
            hi += int'(clk_out); #5;
            if (i == 0) en = 1'b0;
        end
        check("stop_hi_halves", hi, 8);
        check("stop_clk_out", int'(clk_out), 0);
        check("stop_tick", int'(tick), 0);
        t0 = tick_cnt; h = 0;
        repeat (20) begin
            step();
            h += int'(clk_out);
        end
        check("stop_quiet_ticks", tick_cnt - t0, 0);
        check("stop_quiet_hi", h, 0);

        // Reset mid-period of N=5 with a pending ratio.
        load(5);
        step();
        en = 1'b1;
        wait_tick("rst5", 10);
        load(7);
        step();
        check("rst5_hi_before", int'(clk_out), 1);
        #1 reset = 1'b1;
        #1;
        check("rst5_async_low", int'(clk_out), 0);
        en = 1'b0;
        #6 reset = 1'b0;
        step();
        a0 = ack_cnt;
        en = 1'b1;
        wait_tick("post_rst", 5);
        measure(per, hi, flo);
        check("post_rst_period", per, 6);
        check("post_rst_hi", hi, 6);
        measure(per, hi, flo);
        check("post_rst_period2", per, 6);
        check("post_rst_no_ack", ack_cnt - a0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
